// File: rtl/hps_sdram_pattern_test_if.sv
// Core-port bus between the pattern tester (master) and the SDRAM bridge (slave).
// Latency: set by the slave; each request ends with a single core_ready pulse.
// Backpressure: exactly one request outstanding; master holds addr/data/write until core_ready.
interface hps_sdram_pattern_test_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_data_wr;
   logic [DATA_W-1:0] core_data_rd;
   logic              core_write;
   logic              core_start;
   logic              core_ready;

   modport master (
      output core_addr, core_data_wr, core_write, core_start,
      input  core_data_rd, core_ready
   );

   modport slave (
      input  core_addr, core_data_wr, core_write, core_start,
      output core_data_rd, core_ready
   );
endinterface

// File: rtl/hps_sdram_pattern_test.sv
// SDRAM pattern tester: writes WORDS words from BASE, reads them back, reports pass/errors/first bad address.
// Latency: one request cycle plus memory latency per word, one FINISH cycle at the end of a run.
// Backpressure: waits for core_ready on every request; MEMTEST_LFSR_EN enables the LFSR pattern for mode 3.
module hps_sdram_pattern_test #(
   parameter int          ADDR_W    = 30,
   parameter int          DATA_W    = 32,
   parameter int          BASE      = 0,
   parameter int          WORDS     = 1024,
   parameter int          ERR_W     = 16,
   parameter logic [31:0] LFSR_SEED = 32'h1
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic                      go_n,
   input  logic [1:0]                mode,
   hps_sdram_pattern_test_if.master  core,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [ERR_W-1:0]          err_count,
   output logic [ADDR_W-1:0]         first_err_addr
);

   localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);

   // A zero seed would lock the LFSR at zero forever.
   if (LFSR_SEED == 32'h0) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4,
      FINISH  = 3'd5,
      RELEASE = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;
   logic [DATA_W-1:0] rd_exp;

`ifdef MEMTEST_LFSR_EN
   logic [31:0] lfsr_q, lfsr_d;

   // Galois form of x^32+x^22+x^2+x+1, shifting toward bit 0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
   endfunction
`endif

   // Address-derived patterns; mode 3 falls back to mode 0 unless the LFSR overrides it.
   function automatic logic [DATA_W-1:0] base_pat(input logic [1:0]        m,
                                                  input logic [IDX_W-1:0]  i,
                                                  input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] av;
      av = DATA_W'(a);
      case (m)
         2'd1:    return ~av;
         2'd2:    return DATA_W'(1) << (32'(i) % DATA_W);
         default: return av;
      endcase
   endfunction

   assign core.core_addr    = addr_q;
   assign core.core_data_wr = wdata_q;
   assign core.core_write   = write_q;
   // The request pulse is a decode of the REQ states, each of which lasts exactly one cycle.
   assign core.core_start   = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign busy              = busy_q;
   assign done              = done_q;
   assign pass              = pass_q;
   assign err_count         = err_q;
   assign first_err_addr    = ferr_q;

   // Next-state, next-index and result bookkeeping.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
`ifdef MEMTEST_LFSR_EN
      lfsr_d  = lfsr_q;
`endif

      // Expected read data for the word currently outstanding.
      rd_exp = base_pat(mode_q, idx_q, addr_q);
`ifdef MEMTEST_LFSR_EN
      if (mode_q == 2'd3) rd_exp = DATA_W'(lfsr_q);
`endif

      case (state_q)
         IDLE: begin
            if (!go_n) begin
               mode_d  = mode;
               idx_d   = '0;
               err_d   = '0;
               ferr_d  = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               write_d = 1'b1;
`ifdef MEMTEST_LFSR_EN
               lfsr_d  = LFSR_SEED;
`endif
               state_d = WR_REQ;
            end
         end
         WR_REQ: state_d = WR_WAIT;
         WR_WAIT: begin
            if (core.core_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  write_d = 1'b0;
`ifdef MEMTEST_LFSR_EN
                  lfsr_d  = LFSR_SEED;
`endif
                  state_d = RD_REQ;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
`ifdef MEMTEST_LFSR_EN
                  lfsr_d  = lfsr_step(lfsr_q);
`endif
                  state_d = WR_REQ;
               end
            end
         end
         RD_REQ: state_d = RD_WAIT;
         RD_WAIT: begin
            if (core.core_ready) begin
               if (core.core_data_rd != rd_exp) begin
                  if (err_q != '1) err_d = err_q + ERR_W'(1);
                  if (err_q == '0) ferr_d = addr_q;
               end
               if (idx_q == LAST_IDX) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
`ifdef MEMTEST_LFSR_EN
                  lfsr_d  = lfsr_step(lfsr_q);
`endif
                  state_d = RD_REQ;
               end
            end
         end
         FINISH:  state_d = RELEASE;
         // One run per press: wait for the button to come back up.
         RELEASE: if (go_n) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Address and write data are loaded on entry to a request state and held through the wait.
      if ((state_d == WR_REQ) || (state_d == RD_REQ)) begin
         addr_d = BASE_A + ADDR_W'(idx_d);
      end
      if (state_d == WR_REQ) begin
         wdata_d = base_pat(mode_d, idx_d, addr_d);
`ifdef MEMTEST_LFSR_EN
         if (mode_d == 2'd3) wdata_d = DATA_W'(lfsr_d);
`endif
      end
   end

   // State register.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) state_q <= IDLE;
      else                state_q <= state_d;
   end

   // Datapath and result registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         idx_q   <= '0;
         mode_q  <= 2'd0;
         addr_q  <= BASE_A;
         wdata_q <= '0;
         write_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ferr_q  <= '0;
`ifdef MEMTEST_LFSR_EN
         lfsr_q  <= LFSR_SEED;
`endif
      end else begin
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
`ifdef MEMTEST_LFSR_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

endmodule

// File: tb/tb_hps_sdram_pattern_test.sv
// Bench for hps_sdram_pattern_test: table of pattern/fault runs against a behavioural memory.
// Memory answers each request a configurable number of cycles after core_start.
// Hand sequences cover reset with stray ready pulses, a held button and reset during a read.
`timescale 1ns/1ps
module tb_hps_sdram_pattern_test;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int BASE   = 16;
   localparam int WORDS  = 8;
   localparam int ERR_W  = 2;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b0;
   logic              go_n = 1'b1;
   logic [1:0]        mode = 2'd0;
   logic              busy, done, pass;
   logic [ERR_W-1:0]  err_count;
   logic [ADDR_W-1:0] first_err_addr;

   hps_sdram_pattern_test_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   hps_sdram_pattern_test #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE), .WORDS(WORDS),
      .ERR_W(ERR_W), .LFSR_SEED(32'h1)
   ) dut (
      .clk_clk        (clk_clk),
      .reset_reset_n  (reset_reset_n),
      .go_n           (go_n),
      .mode           (mode),
      .core           (bus),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   always #5 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Behavioural memory: fault 1 = bit 3 stuck at 0 at address 19, fault 2 = reads return 0.
   logic [DATA_W-1:0] mem [0:63];
   int                lat = 2;
   int                fault = 0;
   logic              noise = 1'b0;
   int                cnt = 0;
   int                starts = 0;
   int                proto_err = 0;
   logic              pend_wr = 1'b0;
   logic [ADDR_W-1:0] pend_addr = '0;
   logic [DATA_W-1:0] pend_data = '0;
   logic [ADDR_W-1:0] wr_addr_log[$];
   logic [DATA_W-1:0] wr_data_log[$];
   logic [ADDR_W-1:0] rd_addr_log[$];

   // Memory reacts on the falling edge so the DUT sees stable inputs at the rising edge.
   always @(negedge clk_clk) begin
      logic rdy;
      rdy = 1'b0;
      if (cnt != 0) begin
         cnt--;
         if (cnt == 0) begin
            rdy = 1'b1;
            if (pend_wr) begin
               mem[pend_addr[5:0]] = (fault == 1 && pend_addr == 30'd19) ? (pend_data & ~32'h8) : pend_data;
               wr_addr_log.push_back(pend_addr);
               wr_data_log.push_back(pend_data);
            end else begin
               bus.core_data_rd = (fault == 2) ? 32'h0 : mem[pend_addr[5:0]];
               rd_addr_log.push_back(pend_addr);
            end
         end
      end
      if (bus.core_start) begin
         starts++;
         if (cnt != 0) proto_err++;
         cnt       = lat;
         pend_wr   = bus.core_write;
         pend_addr = bus.core_addr;
         pend_data = bus.core_data_wr;
      end
      bus.core_ready = rdy | noise;
   end

   function automatic logic [31:0] exp_pat(input int m, input int i);
      logic [31:0] a;
      a = 32'(BASE + i);
      case (m)
         1: return ~a;
         2: return 32'h1 << (i % 32);
         3: begin
`ifdef MEMTEST_LFSR_EN
            logic [31:0] l;
            l = 32'h1;
            for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
            return l;
`else
            return a;
`endif
         end
         default: return a;
      endcase
   endfunction

   typedef struct {
      int m;
      int flt;
      int e_err;
      int e_first;
      int e_pass;
   } vec_t;
   vec_t vt[8];

   task automatic do_run(input int m, input int flt, input int e_err, input int e_first, input int e_pass);
      int s0, w0, r0, cyc, b;
      @(negedge clk_clk);
      mode  = m[1:0];
      fault = flt;
      s0 = starts; w0 = wr_addr_log.size(); r0 = rd_addr_log.size();
      go_n = 1'b0;
      b = 0;
      do begin @(negedge clk_clk); b++; end while (!busy && b < 20);
      check("run_busy", busy, 1'b1);
      check("run_done_cleared", done, 1'b0);
      cyc = 0;
      while (!done && cyc < 1000) begin @(negedge clk_clk); cyc++; end
      check("run_cycles", cyc, 48);
      check("run_done", done, 1'b1);
      check("run_busy_low", busy, 1'b0);
      check("run_pass", pass, e_pass[0]);
      check("run_err_count", err_count, e_err[ERR_W-1:0]);
      check("run_first_err", first_err_addr, e_first[ADDR_W-1:0]);
      check("run_starts", starts - s0, 2 * WORDS);
      if (wr_addr_log.size() - w0 == WORDS && rd_addr_log.size() - r0 == WORDS) begin
         for (int i = 0; i < WORDS; i++) begin
            check("wr_addr", wr_addr_log[w0 + i], BASE + i);
            check("wr_data", wr_data_log[w0 + i], exp_pat(m, i));
            check("rd_addr", rd_addr_log[r0 + i], BASE + i);
         end
      end else begin
         check("log_sizes", (wr_addr_log.size() - w0) * 256 + (rd_addr_log.size() - r0), WORDS * 256 + WORDS);
      end
      go_n = 1'b1;
      repeat (3) @(negedge clk_clk);
      check("done_held", done, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_pass"}, pass, 1'b0);
      check({tag, "_err"}, err_count, 0);
      check({tag, "_ferr"}, first_err_addr, 0);
      check({tag, "_start"}, bus.core_start, 1'b0);
      check({tag, "_write"}, bus.core_write, 1'b0);
      check({tag, "_addr"}, bus.core_addr, BASE);
      check({tag, "_wdata"}, bus.core_data_wr, 0);
   endtask

   initial begin
      int s0, b, busy_cycles;

      vt[0] = '{0, 0, 0, 0,  1};
      vt[1] = '{1, 1, 1, 19, 0};
      vt[2] = '{1, 2, 3, 16, 0};
      vt[3] = '{2, 0, 0, 0,  1};
      vt[4] = '{3, 0, 0, 0,  1};
      vt[5] = '{0, 1, 0, 0,  1};
      vt[6] = '{2, 2, 3, 16, 0};
      vt[7] = '{2, 1, 1, 19, 0};

      // Reset held three cycles with core_ready toggling.
      reset_reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_clk);
         noise = ~noise;
      end
      @(negedge clk_clk);
      noise = 1'b0;
      check_reset_vals("rst");
      check("rst_no_starts", starts, 0);
      reset_reset_n = 1'b1;
      noise = 1'b1;
      @(negedge clk_clk);
      noise = 1'b0;
      repeat (4) @(negedge clk_clk);
      check("idle_stray_ready", starts, 0);
      check("idle_busy", busy, 1'b0);

      for (int v = 0; v < 8; v++) do_run(vt[v].m, vt[v].flt, vt[v].e_err, vt[v].e_first, vt[v].e_pass);

      // Button held for roughly three runs' worth produces one run.
      @(negedge clk_clk);
      mode = 2'd0; fault = 0;
      s0 = starts;
      go_n = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_clk);
         if (busy) busy_cycles++;
      end
      check("held_starts", starts - s0, 2 * WORDS);
      check("held_busy_cycles", busy_cycles, 48);
      check("held_done", done, 1'b1);
      go_n = 1'b1;
      repeat (3) @(negedge clk_clk);

      // Reset while a read is outstanding; the late ready must be ignored.
      lat = 4;
      go_n = 1'b0;
      b = 0;
      while (!(bus.core_start && !bus.core_write) && b < 200) begin @(negedge clk_clk); b++; end
      check("reach_rd_req", bus.core_start && !bus.core_write, 1'b1);
      go_n = 1'b1;
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      check_reset_vals("midrst");
      s0 = starts;
      repeat (6) @(negedge clk_clk);
      check("late_ready_no_start", starts - s0, 0);
      check("late_ready_busy", busy, 1'b0);
      check("late_ready_err", err_count, 0);
      lat = 2;
      repeat (2) @(negedge clk_clk);

      do_run(0, 0, 0, 0, 1);
      check("protocol", proto_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
